// File: rtl/seq_mult_core_if.sv
// Operand/result bundle between the IO wrapper and the sequential multiplier core.
// The master side drives the request and operands; the slave side returns status and product.
interface seq_mult_core_if #(
  parameter int WIDTH = 8
);
  logic               ena;
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output ena, start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  ena, start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mult_core.sv
// Shift-and-add multiplier, unsigned or two's complement; result and done pulse come WIDTH+2 enabled cycles after start.
// No backpressure: start is only taken in IDLE, and ena=0 freezes every register.
module seq_mult_core #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_mult_core_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_sgn;
  logic               r_neg;
  logic [2*WIDTH:0]   r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH:0]     w_upper_sum;
  logic [2*WIDTH:0]   w_acc_next;
  logic [2*WIDTH-1:0] w_prod_mag;

  // Magnitude of a signed operand; the most negative value maps to 2^(WIDTH-1), still exact unsigned.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic s);
    f_mag = (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  assign w_upper_sum = r_acc[2*WIDTH:WIDTH] + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_next  = {1'b0, w_upper_sum, r_acc[WIDTH-1:1]};
  assign w_prod_mag  = r_acc[2*WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_sgn     <= 1'b0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else if (bus.ena) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mcand  <= bus.a;
            r_mplier <= bus.b;
            r_sgn    <= bus.signed_mode;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_mcand  <= f_mag(r_mcand, r_sgn);
          r_mplier <= f_mag(r_mplier, r_sgn);
          r_neg    <= r_sgn & (r_mcand[WIDTH-1] ^ r_mplier[WIDTH-1]);
          r_acc    <= '0;
          r_cnt    <= '0;
          r_state  <= RUN;
        end
        RUN: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= DONE;
        end
        DONE: begin
          r_product <= r_neg ? -w_prod_mag : w_prod_mag;
          r_done    <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = r_done;
  assign bus.product = r_product;
endmodule

// File: tb/tb_seq_mult_core.sv
// Directed bench for seq_mult_core: vector table plus stall, duplicate-start and async-reset sequences.
module tb_seq_mult_core;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [15:0] last_exp;

  seq_mult_core_if #(.WIDTH(8)) bus ();

  seq_mult_core #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One operation from start to done; optional ena stall and a spurious start while busy.
  task automatic run_op(input logic sm, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] exp, input int stall_at, input int stall_len,
                        input int dup_at, input string tag);
    int k;
    int busy_cnt;
    int exp_lat;
    logic stable;
    exp_lat  = 10 + ((stall_at >= 0) ? stall_len : 0);
    busy_cnt = 0;
    stable   = 1'b1;
    @(negedge clk);
    bus.ena = 1'b1; bus.start = 1'b1; bus.signed_mode = sm; bus.a = ia; bus.b = ib;
    @(posedge clk); #1;
    check({tag, "_busy_after_start"}, {31'd0, bus.busy}, 32'd1);
    if (bus.busy) busy_cnt++;
    k = 0;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (stall_at >= 0 && k == stall_at) bus.ena = 1'b0;
      if (stall_at >= 0 && k == stall_at + stall_len) bus.ena = 1'b1;
      if (dup_at >= 0 && k == dup_at) begin
        bus.start = 1'b1; bus.signed_mode = ~sm; bus.a = 8'h01; bus.b = 8'h01;
      end
      @(posedge clk); #1;
      k++;
      if (bus.busy) busy_cnt++;
      if (!bus.done && bus.product !== last_exp) stable = 1'b0;
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_product_stable"}, {31'd0, stable}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_product"}, {16'd0, bus.product}, {16'd0, exp});
    @(negedge clk);
    bus.start = 1'b0; bus.ena = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_single"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_product_held"}, {16'd0, bus.product}, {16'd0, exp});
    last_exp = exp;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_exp = 16'h0000;
    vecs[0] = '{1'b0, 8'd13,  8'd11,  16'h008F};
    vecs[1] = '{1'b0, 8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{1'b0, 8'd0,   8'd200, 16'h0000};
    vecs[3] = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
    vecs[4] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[5] = '{1'b1, 8'h80,  8'h7F,  16'hC080};
    vecs[6] = '{1'b0, 8'h80,  8'h80,  16'h4000};
    vecs[7] = '{1'b0, 8'hFF,  8'h02,  16'h01FE};
    vecs[8] = '{1'b1, 8'hFF,  8'h02,  16'hFFFE};

    rst_n = 1'b0;
    bus.ena = 1'b1; bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_product", {16'd0, bus.product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp, -1, 0, -1, $sformatf("vec%0d", i));

    run_op(1'b0, 8'd13, 8'd11, 16'h008F, 3, 5, -1, "stall");
    run_op(1'b0, 8'd13, 8'd11, 16'h008F, -1, 0, 3, "dup_start");

    // Async reset between edges while the core is mid-RUN.
    @(negedge clk);
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_product", {16'd0, bus.product}, 32'd0);
    last_exp = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 8'd7, 8'd9, 16'h003F, -1, 0, -1, "after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
